// File: rtl/pe_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_seq_pkg
// Purpose  : Shared types and latency constants for the PE layer sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pe_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SET   = 3'd1,
        S_ACC   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } seq_state_t;

    // Clocks from a PE input (set/en) to the matching change on nnout.
    localparam int PE_LATENCY  = 3;
    // Read latency of the weight, input and bias RAMs.
    localparam int RAM_LATENCY = 1;

endpackage : pe_seq_pkg
`default_nettype wire

// File: rtl/pe_seq_capture.sv
`default_nettype none
// ============================================================================
// Module   : pe_seq_capture
// Purpose  : Delays the per-neuron "last input" flag by the PE latency and
//            registers pe_nnout with its neuron index when it arrives.
// Revision : 1.0 - initial release
// ============================================================================
module pe_seq_capture
    import pe_seq_pkg::*;
#(
    parameter int NNIN_W = 16,
    parameter int BA_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              last_in,
    input  logic [BA_W-1:0]   idx_in,
    input  logic [NNIN_W-1:0] pe_nnout,
    output logic              fire,
    output logic [BA_W-1:0]   fire_idx,
    output logic              out_valid,
    output logic [NNIN_W-1:0] out_data,
    output logic [BA_W-1:0]   out_idx
);

    logic [PE_LATENCY-1:0] r_last_pipe;
    logic [BA_W-1:0]       r_idx_pipe [PE_LATENCY];

    assign fire     = r_last_pipe[PE_LATENCY-1];
    assign fire_idx = r_idx_pipe[PE_LATENCY-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_pipe <= '0;
            for (int i = 0; i < PE_LATENCY; i++) begin
                r_idx_pipe[i] <= '0;
            end
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
        end else begin
            r_last_pipe   <= {r_last_pipe[PE_LATENCY-2:0], last_in};
            r_idx_pipe[0] <= idx_in;
            for (int i = 1; i < PE_LATENCY; i++) begin
                r_idx_pipe[i] <= r_idx_pipe[i-1];
            end
            out_valid <= fire;
            if (fire) begin
                out_data <= pe_nnout;
                out_idx  <= fire_idx;
            end
        end
    end

endmodule : pe_seq_capture
`default_nettype wire

// File: rtl/pe_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pe_layer_sequencer
// Purpose  : Drives one two-MAC PE through a fully-connected layer, fetching
//            bias/weight/input words and capturing one result per neuron.
// Revision : 1.0 - initial release
// ============================================================================
module pe_layer_sequencer
    import pe_seq_pkg::*;
#(
    parameter int COFF_W   = 16,
    parameter int NNIN_W   = 16,
    parameter int NIN_MAX  = 256,
    parameter int NOUT_MAX = 256,
    parameter int WA_W     = 14,
    parameter int IA_W     = $clog2(NIN_MAX/2),
    parameter int BA_W     = $clog2(NOUT_MAX)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [$clog2(NIN_MAX+1)-1:0]   cfg_n_in,
    input  logic [$clog2(NOUT_MAX+1)-1:0]  cfg_n_out,
    input  logic [WA_W-1:0]                cfg_wt_base,
    output logic                           busy,
    output logic                           done,
    output logic                           wt_rd_en,
    output logic [WA_W-1:0]                wt_addr,
    input  logic [2*COFF_W-1:0]            wt_rd_data,
    output logic                           in_rd_en,
    output logic [IA_W-1:0]                in_addr,
    input  logic [2*NNIN_W-1:0]            in_rd_data,
    output logic                           b_rd_en,
    output logic [BA_W-1:0]                b_addr,
    input  logic [COFF_W-1:0]              b_rd_data,
    output logic                           pe_set,
    output logic                           pe_en,
    output logic [COFF_W-1:0]              pe_bias,
    output logic [COFF_W-1:0]              pe_coff1,
    output logic [COFF_W-1:0]              pe_coff2,
    output logic [NNIN_W-1:0]              pe_nnin1,
    output logic [NNIN_W-1:0]              pe_nnin2,
    input  logic [NNIN_W-1:0]              pe_nnout,
    output logic                           out_valid,
    output logic [NNIN_W-1:0]              out_data,
    output logic [BA_W-1:0]                out_idx
);

    localparam int NI_W = $clog2(NIN_MAX+1);
    localparam int NO_W = $clog2(NOUT_MAX+1);

    seq_state_t       r_state;
    logic [NI_W-1:0]  r_pairs;
    logic             r_odd;
    logic [NO_W-1:0]  r_n_out;
    logic [BA_W-1:0]  r_neuron;
    logic [IA_W-1:0]  r_pair;
    logic [WA_W-1:0]  r_wt_next;

    // PE-side controls: issue decisions delayed to line up with RAM data.
    logic             r_pe_set;
    logic             r_pe_en;
    logic             r_pad;
    logic             r_last;
    logic [BA_W-1:0]  r_last_idx;

    logic [NI_W:0]    w_cfg_sum;
    logic [NI_W-1:0]  w_cfg_pairs;
    logic             w_no_pairs;
    logic             w_last_pair;
    logic             w_last_neuron;
    logic             w_cap_last;
    logic             w_cap_fire;
    logic [BA_W-1:0]  w_cap_idx;

    assign w_cfg_sum     = {1'b0, cfg_n_in} + {{NI_W{1'b0}}, 1'b1};
    assign w_cfg_pairs   = w_cfg_sum[NI_W:1];
    assign w_no_pairs    = (r_pairs == '0);
    assign w_last_pair   = (({{(NI_W-IA_W){1'b0}}, r_pair} + NI_W'(1)) == r_pairs);
    assign w_last_neuron = (({{(NO_W-BA_W){1'b0}}, r_neuron} + NO_W'(1)) == r_n_out);
    assign w_cap_last    = (({{(NO_W-BA_W){1'b0}}, w_cap_idx} + NO_W'(1)) == r_n_out);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pairs    <= '0;
            r_odd      <= 1'b0;
            r_n_out    <= '0;
            r_neuron   <= '0;
            r_pair     <= '0;
            r_wt_next  <= '0;
            r_pe_set   <= 1'b0;
            r_pe_en    <= 1'b0;
            r_pad      <= 1'b0;
            r_last     <= 1'b0;
            r_last_idx <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wt_rd_en   <= 1'b0;
            wt_addr    <= '0;
            in_rd_en   <= 1'b0;
            in_addr    <= '0;
            b_rd_en    <= 1'b0;
            b_addr     <= '0;
        end else begin
            wt_rd_en <= 1'b0;
            in_rd_en <= 1'b0;
            b_rd_en  <= 1'b0;
            done     <= 1'b0;

            r_pe_set   <= (r_state == S_SET);
            r_pe_en    <= (r_state == S_ACC);
            r_pad      <= (r_state == S_ACC) && w_last_pair && r_odd;
            r_last     <= ((r_state == S_SET) && w_no_pairs) ||
                          ((r_state == S_ACC) && w_last_pair);
            r_last_idx <= r_neuron;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pairs   <= w_cfg_pairs;
                        r_odd     <= cfg_n_in[0];
                        r_n_out   <= cfg_n_out;
                        r_wt_next <= cfg_wt_base;
                        r_neuron  <= '0;
                        r_pair    <= '0;
                        if (cfg_n_out == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_SET;
                            busy    <= 1'b1;
                            b_rd_en <= 1'b1;
                            b_addr  <= '0;
                        end
                    end
                end
                S_SET: begin
                    if (!w_no_pairs) begin
                        r_state   <= S_ACC;
                        r_pair    <= '0;
                        wt_rd_en  <= 1'b1;
                        in_rd_en  <= 1'b1;
                        wt_addr   <= r_wt_next;
                        r_wt_next <= r_wt_next + 1'b1;
                        in_addr   <= '0;
                    end else if (w_last_neuron) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_neuron <= r_neuron + 1'b1;
                        b_rd_en  <= 1'b1;
                        b_addr   <= r_neuron + 1'b1;
                    end
                end
                S_ACC: begin
                    if (!w_last_pair) begin
                        r_pair    <= r_pair + 1'b1;
                        wt_rd_en  <= 1'b1;
                        in_rd_en  <= 1'b1;
                        wt_addr   <= r_wt_next;
                        r_wt_next <= r_wt_next + 1'b1;
                        in_addr   <= r_pair + 1'b1;
                    end else if (w_last_neuron) begin
                        r_state <= S_DRAIN;
                    end else begin
                        // Next SET follows immediately so the PE never idles mid-layer.
                        r_state  <= S_SET;
                        r_neuron <= r_neuron + 1'b1;
                        b_rd_en  <= 1'b1;
                        b_addr   <= r_neuron + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_cap_fire && w_cap_last) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pe_set   = r_pe_set;
    assign pe_en    = r_pe_en;
    assign pe_bias  = r_pe_set ? b_rd_data : '0;
    assign pe_coff1 = r_pe_en ? wt_rd_data[COFF_W-1:0] : '0;
    // An odd input count leaves the top coefficient of the final word as padding.
    assign pe_coff2 = (r_pe_en && !r_pad) ? wt_rd_data[2*COFF_W-1:COFF_W] : '0;
    assign pe_nnin1 = r_pe_en ? in_rd_data[NNIN_W-1:0] : '0;
    assign pe_nnin2 = r_pe_en ? in_rd_data[2*NNIN_W-1:NNIN_W] : '0;

    pe_seq_capture #(
        .NNIN_W (NNIN_W),
        .BA_W   (BA_W)
    ) u_capture (
        .clk       (clk),
        .rst_n     (rst_n),
        .last_in   (r_last),
        .idx_in    (r_last_idx),
        .pe_nnout  (pe_nnout),
        .fire      (w_cap_fire),
        .fire_idx  (w_cap_idx),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx)
    );

endmodule : pe_layer_sequencer
`default_nettype wire

// File: tb/tb_pe_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_layer_sequencer
// Purpose  : Randomized bench with RAM and PE models and a per-neuron golden sum.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [8:0]  cfg_n_in;
    logic [8:0]  cfg_n_out;
    logic [13:0] cfg_wt_base;
    logic        busy, done;
    logic        wt_rd_en, in_rd_en, b_rd_en;
    logic [13:0] wt_addr;
    logic [6:0]  in_addr;
    logic [7:0]  b_addr;
    logic [31:0] wt_rd_data, in_rd_data;
    logic [15:0] b_rd_data;
    logic        pe_set, pe_en;
    logic [15:0] pe_bias, pe_coff1, pe_coff2, pe_nnin1, pe_nnin2, pe_nnout;
    logic        out_valid;
    logic [15:0] out_data;
    logic [7:0]  out_idx;

    logic [31:0] wt_mem [16384];
    logic [31:0] in_mem [128];
    logic [15:0] b_mem  [256];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int mon_on = 0, mon_base = 0, mon_pairs = 0, mon_odd = 0;
    int wt_cnt = 0, b_cnt = 0, pe_cnt = 0;
    int oq_idx[$];
    int oq_cyc[$];
    logic [15:0] oq_data[$];
    int dq[$];

    longint      pe_acc = 0;
    logic [15:0] pe_d1  = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pe_layer_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_n_in    (cfg_n_in),
        .cfg_n_out   (cfg_n_out),
        .cfg_wt_base (cfg_wt_base),
        .busy        (busy),
        .done        (done),
        .wt_rd_en    (wt_rd_en),
        .wt_addr     (wt_addr),
        .wt_rd_data  (wt_rd_data),
        .in_rd_en    (in_rd_en),
        .in_addr     (in_addr),
        .in_rd_data  (in_rd_data),
        .b_rd_en     (b_rd_en),
        .b_addr      (b_addr),
        .b_rd_data   (b_rd_data),
        .pe_set      (pe_set),
        .pe_en       (pe_en),
        .pe_bias     (pe_bias),
        .pe_coff1    (pe_coff1),
        .pe_coff2    (pe_coff2),
        .pe_nnin1    (pe_nnin1),
        .pe_nnin2    (pe_nnin2),
        .pe_nnout    (pe_nnout),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_idx     (out_idx)
    );

    function automatic longint sx(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Sync-read RAMs.
    always @(posedge clk) begin
        if (wt_rd_en) wt_rd_data <= wt_mem[wt_addr];
        if (in_rd_en) in_rd_data <= in_mem[in_addr];
        if (b_rd_en)  b_rd_data  <= b_mem[b_addr];
    end

    // Behavioural PE: Q8 accumulator, result visible 3 clocks after set/en.
    always @(posedge clk) begin
        if (pe_set)
            pe_acc <= sx(pe_bias) <<< 8;
        else if (pe_en)
            pe_acc <= pe_acc + sx(pe_coff1) * sx(pe_nnin1) + sx(pe_coff2) * sx(pe_nnin2);
        pe_d1    <= 16'(pe_acc >>> 8);
        pe_nnout <= pe_d1;
    end

    always @(negedge clk) begin
        if (mon_on != 0) begin
            check_val("pe_set_en_excl", 64'(pe_set & pe_en), 64'd0);
            if (wt_rd_en) begin
                check_val("wt_addr", 64'(wt_addr), 64'((mon_base + wt_cnt) % 16384));
                check_val("in_rd_en", 64'(in_rd_en), 64'd1);
                if (mon_pairs != 0)
                    check_val("in_addr", 64'(in_addr), 64'(wt_cnt % mon_pairs));
                wt_cnt++;
            end
            if (b_rd_en) begin
                check_val("b_addr", 64'(b_addr), 64'(b_cnt % 256));
                b_cnt++;
            end
            if (pe_en) begin
                if (mon_odd != 0 && mon_pairs != 0 && (pe_cnt % mon_pairs) == mon_pairs - 1)
                    check_val("coff2_pad", 64'(pe_coff2), 64'd0);
                pe_cnt++;
            end else begin
                check_val("pe_idle_zero", {pe_coff1, pe_coff2, pe_nnin1, pe_nnin2}, 64'd0);
            end
        end
        if (out_valid) begin
            oq_idx.push_back(int'(out_idx));
            oq_data.push_back(out_data);
            oq_cyc.push_back(cyc);
        end
        if (done) dq.push_back(cyc);
    end

    task automatic clear_queues();
        oq_idx.delete();
        oq_data.delete();
        oq_cyc.delete();
        dq.delete();
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_layer(input int n_in, input int n_out, input int base,
                             input bit fixed, input bit poke);
        int p, s, budget, exp_done;
        longint sum;
        logic [31:0] w, x;
        logic [15:0] exp_d;
        p = (n_in + 1) / 2;
        for (int i = 0; i < 16384; i++) wt_mem[i] = fixed ? 32'h1000_1000 : $urandom;
        for (int i = 0; i < 128; i++)   in_mem[i] = fixed ? 32'h0080_0080 : $urandom;
        for (int i = 0; i < 256; i++)   b_mem[i]  = fixed ? 16'h0100 : 16'($urandom);
        clear_queues();
        mon_base = base; mon_pairs = p; mon_odd = n_in % 2;
        wt_cnt = 0; b_cnt = 0; pe_cnt = 0; mon_on = 1;

        cfg_n_in = 9'(n_in); cfg_n_out = 9'(n_out); cfg_wt_base = 14'(base);
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
        cfg_n_in = 9'($urandom); cfg_n_out = 9'($urandom); cfg_wt_base = 14'($urandom);

        budget = n_out * (p + 1) + 30;
        for (int i = 0; i < budget && dq.size() == 0; i++) begin
            start = (poke && i == 4);
            tick();
        end
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        mon_on = 0;

        exp_done = (n_out == 0) ? s + 2 : s + 6 + p + (n_out - 1) * (p + 1) + 1;
        check_val("done_count", 64'(dq.size()), 64'd1);
        if (dq.size() > 0) check_val("done_cycle", 64'(dq[0] - s), 64'(exp_done - s));
        check_val("out_count", 64'(oq_idx.size()), 64'(n_out));
        check_val("b_reads", 64'(b_cnt), 64'(n_out));
        check_val("wt_reads", 64'(wt_cnt), 64'(n_out * p));
        check_val("busy_after", 64'(busy), 64'd0);

        for (int k = 0; k < n_out && k < oq_idx.size(); k++) begin
            sum = sx(b_mem[k]) <<< 8;
            for (int j = 0; j < p; j++) begin
                w = wt_mem[(base + k * p + j) % 16384];
                x = in_mem[j];
                sum += sx(w[15:0]) * sx(x[15:0]);
                if (!(n_in % 2 == 1 && j == p - 1))
                    sum += sx(w[31:16]) * sx(x[31:16]);
            end
            exp_d = 16'(sum >>> 8);
            check_val("out_idx", 64'(oq_idx[k]), 64'(k));
            check_val("out_data", 64'(oq_data[k]), 64'(exp_d));
            check_val("out_cycle", 64'(oq_cyc[k] - s), 64'(6 + p + k * (p + 1)));
        end
    endtask

    task automatic reset_abort();
        mon_on = 0;
        for (int i = 0; i < 128; i++) in_mem[i] = $urandom;
        cfg_n_in = 9'd8; cfg_n_out = 9'd4; cfg_wt_base = 14'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_val("mid_acc_busy", 64'(busy & wt_rd_en), 64'd1);
        rst_n = 1'b0;
        tick();
        check_val("abort_outputs_zero",
                  64'(|{busy, done, wt_rd_en, wt_addr, in_rd_en, in_addr, b_rd_en, b_addr,
                        pe_set, pe_en, pe_bias, pe_coff1, pe_coff2, pe_nnin1, pe_nnin2,
                        out_valid, out_data, out_idx}), 64'd0);
        tick();
        rst_n = 1'b1;
        clear_queues();
        for (int i = 0; i < 20; i++) tick();
        check_val("abort_no_out", 64'(oq_idx.size()), 64'd0);
        check_val("abort_no_done", 64'(dq.size()), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        cfg_n_in = '0; cfg_n_out = '0; cfg_wt_base = '0;
        for (int i = 0; i < 3; i++) tick();
        check_val("rst_ctrl", 64'({busy, done, wt_rd_en, in_rd_en, b_rd_en, pe_set, pe_en, out_valid}), 64'd0);
        check_val("rst_data", {pe_bias, pe_coff1, out_data, 8'd0, out_idx}, 64'd0);
        rst_n = 1'b1;
        tick();

        run_layer(4, 1, 37, 1'b1, 1'b0);
        run_layer(3, 2, 500, 1'b0, 1'b0);
        run_layer(0, 3, 0, 1'b0, 1'b0);
        run_layer(5, 0, 12, 1'b0, 1'b0);
        run_layer(7, 3, 16380, 1'b0, 1'b1);
        reset_abort();
        run_layer(6, 2, 9, 1'b0, 1'b0);
        for (int t = 0; t < 4; t++)
            run_layer(int'($urandom_range(0, 21)), int'($urandom_range(1, 6)),
                      int'($urandom_range(0, 16383)), 1'b0, t == 1);
        run_layer(256, 256, int'($urandom_range(0, 16383)), 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_pe_layer_sequencer
`default_nettype wire
